// File: rtl/demux13_stream_pkg.sv
// Shared constants for the 1-to-3 stream demultiplexer: select encodings and
// per-channel buffer depth.
package demux13_stream_pkg;

    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;
    localparam logic [1:0] SEL_ILL = 2'b11;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned NUM_CH     = 3;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO with 1-bit wrapping pointers and an occupancy count.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo2
    import demux13_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/demux13_stream.sv
// Routes a valid/ready input stream to one of three buffered output channels;
// words with the illegal select are accepted, dropped and counted.
module demux13_stream
    import demux13_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_sel,
    output logic [2:0]            out_valid,
    input  logic [2:0]            out_ready,
    output logic [DATA_WIDTH-1:0] out_data0,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic [DATA_WIDTH-1:0] out_data2,
    output logic                  err,
    output logic [7:0]            err_cnt
);

    logic [NUM_CH-1:0]     full_w;
    logic [NUM_CH-1:0]     empty_w;
    logic [NUM_CH-1:0]     push_w;
    logic [DATA_WIDTH-1:0] dout_w [NUM_CH];
    logic                  accept;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    // Readiness depends only on stored occupancy, never on out_ready.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (in_sel)
                SEL_CH0: in_ready = !full_w[0];
                SEL_CH1: in_ready = !full_w[1];
                SEL_CH2: in_ready = !full_w[2];
                default: in_ready = 1'b1;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign push_w[g] = accept && (in_sel == 2'(g));

        sync_fifo2 #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (push_w[g]),
            .pop  (out_ready[g]),
            .din  (in_data),
            .dout (dout_w[g]),
            .full (full_w[g]),
            .empty(empty_w[g])
        );
    end

    assign out_valid = ~empty_w;
    assign out_data0 = dout_w[0];
    assign out_data1 = dout_w[1];
    assign out_data2 = dout_w[2];

    always_comb begin
        err_d     = accept && (in_sel == SEL_ILL);
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: doc/demux13_stream.md
DEMUX13_STREAM -- requirements
Module: demux13_stream

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the payload on the input and on every output channel.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream offers a word.
REQ-005 Port: in_ready  output  1  block accepts the offered word this cycle.
REQ-006 Port: in_data  input  DATA_WIDTH  payload.
REQ-007 Port: in_sel  input  2  destination: 2'b00 ch0, 2'b01 ch1, 2'b10 ch2, 2'b11 illegal.
REQ-008 Port: out_valid  output  3  bit i set when channel i holds a word.
REQ-009 Port: out_ready  input  3  bit i set when the consumer of channel i takes the word.
REQ-010 Port: out_data0 / out_data1 / out_data2  output  DATA_WIDTH each  head word of each channel.
REQ-011 Port: err  output  1  one-cycle pulse, registered, for each accepted illegal-sel word.
REQ-012 Port: err_cnt  output  8  saturating count of illegal-sel words.

Function
REQ-013 Each channel SHALL buffer words in its own 2-entry FIFO with an occupancy count of 0..2.
REQ-014 Input transfer SHALL occur when in_valid && in_ready.
REQ-015 in_ready SHALL equal !full[in_sel] for in_sel 0..2, and 1 for in_sel 2'b11.
REQ-016 in_ready SHALL NOT depend combinationally on out_ready; a full channel does not accept input in the same cycle it pops.
REQ-017 Output transfer on channel i SHALL occur when out_valid[i] && out_ready[i].
REQ-018 out_valid[i] SHALL equal (count_i != 0).
REQ-019 out_data_i SHALL present the oldest stored word of channel i.
REQ-020 Latency SHALL be one cycle: a word accepted in cycle N is visible on out_valid/out_data in cycle N+1.
REQ-021 Words to the same channel SHALL leave in acceptance order.
REQ-022 Channels SHALL be independent; a full or stalled channel never blocks input addressed to another channel.
REQ-023 A push and a pop on the same non-full channel in the same cycle SHALL both occur and leave the count unchanged.
REQ-024 On a pop from count 1 with no push, the channel SHALL go empty and out_valid[i] SHALL be 0 in the next cycle.
REQ-025 Read and write pointers SHALL be 1 bit each and wrap 1 -> 0.
REQ-026 An illegal-sel word SHALL be accepted and discarded, and SHALL assert err for exactly the next cycle.
REQ-027 Each illegal-sel word SHALL increment err_cnt, holding at 255.
REQ-028 in_data and in_sel SHALL be ignored when in_valid is 0.
REQ-029 out_ready[i] SHALL be ignored when channel i is empty.

Reset
REQ-030 While rst is high at a clock edge, all counts and pointers SHALL go to 0, out_valid SHALL be 3'b000, err SHALL be 0, err_cnt SHALL be 0, and storage words SHALL be 0.
REQ-031 Reset mid-operation SHALL discard all buffered words; no transfer completes in a reset cycle.
REQ-032 While rst is high, in_ready SHALL be 0.

Structure
REQ-033 A shared package SHALL hold the select encodings (SEL_CH0=2'b00, SEL_CH1=2'b01, SEL_CH2=2'b10, SEL_ILL=2'b11) and the FIFO depth constant (2).
REQ-034 The per-channel buffer SHALL be a sub-module, sync_fifo2 (parameter DATA_WIDTH; ports push, pop, din, dout, full, empty), instantiated three times.
REQ-035 The top level SHALL contain only push decode, in_ready selection, and the error logic.

Verification
REQ-036 Reset, then in_valid=1, in_sel=1, in_data=0xA5A5A5A5, out_ready=0 -> next cycle out_valid=3'b010 and out_data1=0xA5A5A5A5.
REQ-037 With out_ready[0]=0, push 0x1 then 0x2 to ch0 -> in_ready=0 for sel 0, in_ready=1 for sel 2; then raise out_ready[0] -> 0x1 leaves, then 0x2.
REQ-038 With ch2 at count 1, push and pop ch2 in the same cycle -> count stays 1 and the new word becomes the head.
REQ-039 Send 260 words with in_sel=3 -> err pulses 260 times, err_cnt=255, and out_valid stays 0.
REQ-040 With ch0 full and ch1 holding 1 word, assert rst for one cycle -> out_valid=0, err_cnt=0, and the next push to ch0 is accepted.
